// File: rtl/truth_table_9_4_pkg.sv
// Shared constants and the 9-input popcount truth table used by both
// canonical-form realisations of truth_table_9_4.
package truth_table_9_4_pkg;

   localparam int unsigned N_IN   = 9;
   localparam int unsigned N_OUT  = 4;
   localparam int unsigned N_ROWS = 512;

   // Bit [0] is the MSB of the table word (y0y1y2y3).
   typedef logic [0:N_OUT-1] tt_word_t;
   typedef tt_word_t [0:N_ROWS-1] tt_table_t;

   // Build entry[m] = number of ones in m. Values stay within 0..9.
   function automatic tt_table_t gen_tt_9_4();
      tt_table_t  t;
      logic [3:0] cnt;
      t = '0;
      for (int unsigned m = 0; m < N_ROWS; m++) begin
         cnt = '0;
         for (int unsigned b = 0; b < N_IN; b++) begin
            cnt = cnt + 4'((m >> b) & 32'd1);
         end
         t[m] = cnt;
      end
      return t;
   endfunction

   localparam tt_table_t TT_9_4 = gen_tt_9_4();

endpackage

// File: rtl/tt_forms_9_4.sv
// Purely combinational realisation of TT_9_4 in two independent canonical
// forms: DNF (OR of selected minterms) and CNF (AND of selected maxterms).
module tt_forms_9_4
   import truth_table_9_4_pkg::*;
(
   input  logic [N_IN-1:0] i_x,
   output tt_word_t        y_dnf,
   output tt_word_t        y_cnf
);

   for (genvar b = 0; b < N_OUT; b++) begin : g_bit
      logic [N_ROWS-1:0] dnf_term;
      logic [N_ROWS-1:0] cnf_term;

      for (genvar m = 0; m < N_ROWS; m++) begin : g_row
         localparam logic [N_IN-1:0] ROW = N_IN'(m);
         localparam logic            BIT = TT_9_4[m][b];

         // Minterm contributes only where the table bit is 1.
         assign dnf_term[m] = (i_x == ROW) & BIT;
         // Maxterm constrains only where the table bit is 0.
         assign cnf_term[m] = (i_x != ROW) | BIT;
      end

      assign y_dnf[b] = |dnf_term;
      assign y_cnf[b] = &cnf_term;
   end

endmodule

// File: rtl/truth_table_9_4.sv
// Registered 9-in/4-out popcount lookup with DNF/CNF cross-check.
// OUT_REG=1 registers both results (1-cycle latency); OUT_REG=0 passes them
// through combinationally. o_mismatch is always registered.
module truth_table_9_4
   import truth_table_9_4_pkg::*;
#(
   parameter int unsigned OUT_REG = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IN-1:0]  i_x,
   output logic [0:N_OUT-1] o_y_dnf,
   output logic [0:N_OUT-1] o_y_cnf,
   output logic             o_mismatch
);

   tt_word_t y_dnf_c;
   tt_word_t y_cnf_c;
   logic     mismatch_d;
   logic     mismatch_q;

   tt_forms_9_4 u_forms (
      .i_x   (i_x),
      .y_dnf (y_dnf_c),
      .y_cnf (y_cnf_c)
   );

   // Compare the two forms from the same cycle so the flag aligns with outputs.
   always_comb begin
      mismatch_d = 1'b0;
      mismatch_d = (y_dnf_c != y_cnf_c);
   end

   // Mismatch flag register, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end

   assign o_mismatch = mismatch_q;

   if (OUT_REG != 0) begin : g_out_reg
      tt_word_t y_dnf_d;
      tt_word_t y_dnf_q;
      tt_word_t y_cnf_d;
      tt_word_t y_cnf_q;

      // Next values for the output registers.
      always_comb begin
         y_dnf_d = '0;
         y_cnf_d = '0;
         y_dnf_d = y_dnf_c;
         y_cnf_d = y_cnf_c;
      end

      // Output registers, synchronous active-low reset.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            y_dnf_q <= '0;
            y_cnf_q <= '0;
         end else begin
            y_dnf_q <= y_dnf_d;
            y_cnf_q <= y_cnf_d;
         end
      end

      assign o_y_dnf = y_dnf_q;
      assign o_y_cnf = y_cnf_q;
   end else begin : g_out_comb
      assign o_y_dnf = y_dnf_c;
      assign o_y_cnf = y_cnf_c;
   end

endmodule

// File: tb/tb_truth_table_9_4.sv
// Self-checking bench for truth_table_9_4: registered and combinational builds
// checked against an arithmetic bit-count reference.
module tb_truth_table_9_4;

   logic       clk;
   logic       rst_n;
   logic [8:0] i_x;
   logic [0:3] r_dnf, r_cnf, c_dnf, c_cnf;
   logic       r_mis, c_mis;

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   truth_table_9_4 #(.OUT_REG(1)) u_dut_reg (
      .clk(clk), .rst_n(rst_n), .i_x(i_x),
      .o_y_dnf(r_dnf), .o_y_cnf(r_cnf), .o_mismatch(r_mis)
   );

   truth_table_9_4 #(.OUT_REG(0)) u_dut_comb (
      .clk(clk), .rst_n(rst_n), .i_x(i_x),
      .o_y_dnf(c_dnf), .o_y_cnf(c_cnf), .o_mismatch(c_mis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] x;
      logic [3:0] y;
   } vec_t;

   vec_t vecs [8];

   // Reference: count the ones by plain arithmetic.
   function automatic logic [3:0] ref_count(input logic [8:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 9; i++) n += (v >> i) % 2;
      return 4'(n);
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic check_reg(input string tag, input logic [3:0] exp);
      check($sformatf("%s reg dnf", tag), r_dnf, exp);
      check($sformatf("%s reg cnf", tag), r_cnf, exp);
      check($sformatf("%s reg mismatch", tag), {3'b0, r_mis}, 4'd0);
   endtask

   task automatic check_comb(input string tag, input logic [3:0] exp);
      check($sformatf("%s comb dnf", tag), c_dnf, exp);
      check($sformatf("%s comb cnf", tag), c_cnf, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{9'b000000001, 4'b0001};
      vecs[1] = '{9'b100000000, 4'b0001};
      vecs[2] = '{9'b101010101, 4'b0101};
      vecs[3] = '{9'b011111110, 4'b0111};
      vecs[4] = '{9'b111101111, 4'b1000};
      vecs[5] = '{9'h000,       4'b0000};
      vecs[6] = '{9'h1FF,       4'b1001};
      vecs[7] = '{9'h0FF,       4'b1000};

      // Reset held for two edges with all inputs high.
      rst_n = 1'b0;
      i_x   = 9'h1FF;
      tick();
      tick();
      check_reg("reset", 4'b0000);
      check("reset comb mismatch", {3'b0, c_mis}, 4'd0);
      check_comb("reset passthrough", 4'b1001);

      rst_n = 1'b1;
      tick();
      check_reg("post-reset", 4'b1001);

      // Directed table vectors.
      for (int i = 0; i < 8; i++) begin
         i_x = vecs[i].x;
         #1;
         check_comb($sformatf("vec%0d", i), vecs[i].y);
         tick();
         check_reg($sformatf("vec%0d", i), vecs[i].y);
      end

      // Exhaustive sweep with a one-cycle reset pulse at 300.
      for (int m = 0; m < 512; m++) begin
         i_x = 9'(m);
         if (m == 300) rst_n = 1'b0;
         #1;
         check_comb($sformatf("sweep %0d", m), ref_count(9'(m)));
         tick();
         if (m == 300) begin
            check_reg("sweep reset", 4'b0000);
            check("sweep reset comb mismatch", {3'b0, c_mis}, 4'd0);
         end else begin
            check_reg($sformatf("sweep %0d", m), ref_count(9'(m)));
         end
         rst_n = 1'b1;
      end

      // Random back-to-back inputs.
      for (int k = 0; k < 300; k++) begin
         logic [8:0] v;
         v   = 9'($urandom_range(0, 511));
         i_x = v;
         #1;
         check_comb($sformatf("rand %h", v), ref_count(v));
         tick();
         check_reg($sformatf("rand %h", v), ref_count(v));
         check("rand comb mismatch", {3'b0, c_mis}, 4'd0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/truth_table_9_4.md
Name: truth_table_9_4

Overview:
- Registered 9-input, 4-output Boolean function block. The function is specified as a 512-entry truth table.
- The same table is realised in two independent canonical forms:
  - DNF: an OR of the minterms whose table entry bit is 1.
  - CNF: an AND of the maxterms whose table entry bit is 0.
- Both results are registered, and a mismatch flag is raised whenever they disagree.
- Used as a cross-checked combinational lookup inside datapaths. Also serves as the reference block for the truth-table-to-logic flow.

Parameters:
- OUT_REG, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational. In mode 0, clk/rst_n affect only o_mismatch.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- i_x  input  9  function inputs; i_x[0] is variable x0, …, i_x[8] is x8.
- o_y_dnf  output  4 ([0:3])  DNF-form result; bit [0] is the MSB of the table word.
- o_y_cnf  output  4 ([0:3])  CNF-form result; same bit order as o_y_dnf.
- o_mismatch  output  1  high when the registered o_y_dnf differs from o_y_cnf.

Behaviour:
- Function definition (fixed truth table): entry[m] = population count of m, for m = 0..511, as a 4-bit word.
  - Written y0y1y2y3 with y0 as MSB.
  - Range 0..9, so codes 1010..1111 never occur.
- DNF path:
  - For each output bit b: y_dnf[b] = OR over m of (i_x == m) AND table[m][b].
  - Built as an explicit minterm OR. Optimisation to popcount arithmetic is not permitted; the two-form cross-check is the purpose of the block.
- CNF path:
  - For each output bit b: y_cnf[b] = AND over m of (i_x != m) OR table[m][b].
  - Built as an explicit maxterm AND.
- Both paths must read the same shared table constant.
- OUT_REG=1:
  - On each rising clk edge: if rst_n==0, o_y_dnf, o_y_cnf and o_mismatch all load 0.
  - Otherwise o_y_dnf and o_y_cnf load the combinational results for the current i_x.
  - o_mismatch loads (y_dnf != y_cnf), evaluated from the same-cycle combinational results, so it aligns with the outputs.
  - Latency is exactly 1 cycle. No handshake; a new input is accepted every cycle.
- OUT_REG=0:
  - o_y_dnf and o_y_cnf are purely combinational from i_x.
  - o_mismatch is registered as above.
- Reset values: o_y_dnf=0000, o_y_cnf=0000, o_mismatch=0.
  - Because table[0]=0000, the reset state equals the response to i_x=0.
- Reset mid-operation: the cycle after rst_n low, all outputs are 0 regardless of i_x. The first valid result appears one edge after rst_n returns high.
- X on i_x: no special handling is required.
- Boundary inputs: i_x=0 gives 0000; i_x=9'h1FF gives 1001.
- In correct hardware o_mismatch is never 1. It exists for fault detection and formal checks.

Decomposition:
- Package truth_table_9_4_pkg holds:
  - Constants N_IN=9, N_OUT=4, N_ROWS=512.
  - typedef logic [0:3] tt_word_t.
  - Constant array TT_9_4[0:511] of tt_word_t, generated as the popcount table.
- One sub-module, tt_forms_9_4: purely combinational.
  - Input: i_x.
  - Outputs: y_dnf and y_cnf, built with generate loops over rows and bits.
- The top level adds the registers, the OUT_REG mux and the mismatch compare.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with i_x=9'h1FF -> o_y_dnf=o_y_cnf=0000, o_mismatch=0; release, next edge -> 1001 on both outputs.
- Single-bit inputs: i_x=9'b000000001 -> 0001; i_x=9'b100000000 -> 0001 one cycle later on both outputs.
- Pattern: i_x=9'b101010101 -> 0101; i_x=9'b011111110 -> 0111; i_x=9'b111101111 -> 1000.
- Exhaustive sweep: i_x=0..511, one value per cycle -> output at cycle n+1 equals popcount(i_x at n) on both forms; o_mismatch stays 0 for all 512 vectors.
- Reset mid-sweep: assert rst_n=0 at i_x=300 for one cycle -> outputs 0000 the following edge; sweep resumes with correct 1-cycle-delayed values.
- OUT_REG=0 build: i_x=9'h0FF -> o_y_dnf=o_y_cnf=1000 combinationally, within the same cycle.
